// File: rtl/ram_arbiter.sv
// ram_arbiter: merges icache and dcache RAM bursts onto a single RAM port.
// One burst in flight at a time; round-robin between caches, writes first
// when the winning cache asks for both.
//
// state | meaning
// IDLE  | no owner, arbitrate between requesting caches
// AR    | forwarding owner's read address until the RAM accepts it
// R     | forwarding read beats to the owner until rlast
// AW    | forwarding owner's write address until the RAM accepts it
// W     | forwarding RAM write-beat requests to the owner until wlast
module ram_arbiter #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] i_ram_awaddr,
  input  logic [LWIDTH-1:0] i_ram_awlen,
  input  logic              i_ram_awvalid,
  output logic              i_ram_awready,
  input  logic [DWIDTH-1:0] i_ram_wdata,
  output logic              i_ram_wvalid,
  input  logic              i_ram_wready,
  output logic              i_ram_wlast,
  input  logic [AWIDTH-1:0] i_ram_araddr,
  input  logic [LWIDTH-1:0] i_ram_arlen,
  input  logic              i_ram_arvalid,
  output logic              i_ram_arready,
  output logic [DWIDTH-1:0] i_ram_rdata,
  output logic              i_ram_rvalid,
  input  logic              i_ram_rready,
  output logic              i_ram_rlast,
  input  logic [AWIDTH-1:0] d_ram_awaddr,
  input  logic [LWIDTH-1:0] d_ram_awlen,
  input  logic              d_ram_awvalid,
  output logic              d_ram_awready,
  input  logic [DWIDTH-1:0] d_ram_wdata,
  output logic              d_ram_wvalid,
  input  logic              d_ram_wready,
  output logic              d_ram_wlast,
  input  logic [AWIDTH-1:0] d_ram_araddr,
  input  logic [LWIDTH-1:0] d_ram_arlen,
  input  logic              d_ram_arvalid,
  output logic              d_ram_arready,
  output logic [DWIDTH-1:0] d_ram_rdata,
  output logic              d_ram_rvalid,
  input  logic              d_ram_rready,
  output logic              d_ram_rlast,
  output logic [AWIDTH-1:0] mem_awaddr,
  output logic [LWIDTH-1:0] mem_awlen,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_wvalid,
  output logic              mem_wready,
  input  logic              mem_wlast,
  output logic [AWIDTH-1:0] mem_araddr,
  output logic [LWIDTH-1:0] mem_arlen,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic              mem_rlast,
  output logic [1:0]        grant,
  output logic              proto_err
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_grant_q, last_grant_d;  // 1 = dcache was last owner
  logic [LWIDTH-1:0] len_q, len_d;
  logic [LWIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic own_i, own_d, req_i, req_d, pick_d, pick_wr, beat, beat_last;

  assign own_i = grant_q[0];
  assign own_d = grant_q[1];
  assign req_i = i_ram_awvalid | i_ram_arvalid;
  assign req_d = d_ram_awvalid | d_ram_arvalid;

  // Read data is broadcast; only rvalid/rlast are steered to the owner.
  assign i_ram_rdata = mem_rdata;
  assign d_ram_rdata = mem_rdata;
  assign grant       = grant_q;
  assign proto_err   = proto_err_q;

  // Steer the owner's channel onto the RAM port; everything gated by state so
  // reset drops all handshakes immediately.
  always_comb begin
    mem_awaddr    = own_d ? d_ram_awaddr : i_ram_awaddr;
    mem_awlen     = own_d ? d_ram_awlen  : i_ram_awlen;
    mem_awvalid   = (state_q == S_AW) & (own_d ? d_ram_awvalid : i_ram_awvalid);
    i_ram_awready = (state_q == S_AW) & own_i & mem_awready;
    d_ram_awready = (state_q == S_AW) & own_d & mem_awready;

    mem_wdata     = own_d ? d_ram_wdata : i_ram_wdata;
    mem_wready    = (state_q == S_W) & (own_d ? d_ram_wready : i_ram_wready);
    i_ram_wvalid  = (state_q == S_W) & own_i & mem_wvalid;
    d_ram_wvalid  = (state_q == S_W) & own_d & mem_wvalid;
    i_ram_wlast   = (state_q == S_W) & own_i & mem_wlast;
    d_ram_wlast   = (state_q == S_W) & own_d & mem_wlast;

    mem_araddr    = own_d ? d_ram_araddr : i_ram_araddr;
    mem_arlen     = own_d ? d_ram_arlen  : i_ram_arlen;
    mem_arvalid   = (state_q == S_AR) & (own_d ? d_ram_arvalid : i_ram_arvalid);
    i_ram_arready = (state_q == S_AR) & own_i & mem_arready;
    d_ram_arready = (state_q == S_AR) & own_d & mem_arready;

    mem_rready    = (state_q == S_R) & (own_d ? d_ram_rready : i_ram_rready);
    i_ram_rvalid  = (state_q == S_R) & own_i & mem_rvalid;
    d_ram_rvalid  = (state_q == S_R) & own_d & mem_rvalid;
    i_ram_rlast   = (state_q == S_R) & own_i & mem_rlast;
    d_ram_rlast   = (state_q == S_R) & own_d & mem_rlast;
  end

  assign beat      = ((state_q == S_R) & mem_rvalid & mem_rready) |
                     ((state_q == S_W) & mem_wvalid & mem_wready);
  assign beat_last = (state_q == S_R) ? mem_rlast : mem_wlast;
  // On a tie the cache that did not own the port last time wins.
  assign pick_d    = req_d & (~req_i | ~last_grant_q);
  assign pick_wr   = pick_d ? d_ram_awvalid : i_ram_awvalid;

  // Next-state, ownership and beat-count bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_i | req_d) begin
          grant_d      = pick_d ? 2'b10 : 2'b01;
          last_grant_d = pick_d;
          if (pick_d) len_d = d_ram_awvalid ? d_ram_awlen : d_ram_arlen;
          else        len_d = i_ram_awvalid ? i_ram_awlen : i_ram_arlen;
          state_d      = pick_wr ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (mem_arvalid & mem_arready) begin
          state_d    = S_R;
          beat_cnt_d = '0;
        end
      end
      S_AW: begin
        if (mem_awvalid & mem_awready) begin
          state_d    = S_W;
          beat_cnt_d = '0;
        end
      end
      S_R, S_W: begin
        if (beat) begin
          if (beat_last) begin
            if (beat_cnt_q != len_q) proto_err_d = 1'b1;
            state_d = S_IDLE;
            grant_d = 2'b00;
          end else begin
            if (beat_cnt_q == len_q) proto_err_d = 1'b1;
            // Saturate so an overlong burst cannot wrap back to a matching count.
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + LWIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
